// File: rtl/mem_io_responder.sv
// mem_io_responder: request port in front of an inferred synchronous RAM and a small
// memory-mapped I/O bank (switches, LEDs, free-running timer with compare/match flag).
module mem_io_responder #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [15:0] IO_BASE    = 16'hFF00,
    parameter int          SW_WIDTH   = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                we,
    input  logic [15:0]         addr,
    input  logic [15:0]         wdata,
    output logic [15:0]         rdata,
    output logic                rvalid,
    input  logic [SW_WIDTH-1:0] switches,
    output logic [SW_WIDTH-1:0] leds,
    output logic                irq
);
    logic [15:0]         mem [2**ADDR_WIDTH];
    logic                io_sel, io_wr, io_q, rvalid_q, match_q, match_d;
    logic [15:0]         off, io_rdata, io_rd_q, ram_rd_q, rdata_q;
    logic [15:0]         timer_q, cmp_q, cmp_d;
    logic [SW_WIDTH-1:0] sw_s1_q, sw_s2_q, leds_q, leds_d;

    assign io_sel = addr >= IO_BASE;
    assign off    = addr - IO_BASE;
    assign io_wr  = req & we & io_sel;

    always_comb begin
        io_rdata = off == 16'd0 ? 16'(sw_s2_q) :
                   off == 16'd1 ? 16'(leds_q)  :
                   off == 16'd2 ? timer_q      :
                   off == 16'd3 ? cmp_q        :
                   off == 16'd4 ? {15'd0, match_q} : 16'd0;
        leds_d  = io_wr && off == 16'd1 ? wdata[SW_WIDTH-1:0] : leds_q;
        cmp_d   = io_wr && off == 16'd3 ? wdata : cmp_q;
        // a match on the same edge as a write-1-clear keeps the flag set
        match_d = (timer_q == cmp_q) | (match_q & ~(io_wr && off == 16'd4 && wdata[0]));
    end

    // RAM, synchroniser and response-side data need no reset; they are only observed behind rvalid
    always_ff @(posedge clk) begin
        if (req && we && !io_sel) mem[addr[ADDR_WIDTH-1:0]] <= wdata;
        ram_rd_q <= mem[addr[ADDR_WIDTH-1:0]];
        io_rd_q  <= io_rdata;
        io_q     <= io_sel;
        sw_s1_q  <= switches;
        sw_s2_q  <= sw_s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 16'd0;
            leds_q   <= '0;
            timer_q  <= 16'd0;
            cmp_q    <= 16'hFFFF;
            match_q  <= 1'b0;
        end else begin
            rvalid_q <= req & ~we;
            rdata_q  <= rdata;
            leds_q   <= leds_d;
            timer_q  <= timer_q + 16'd1;
            cmp_q    <= cmp_d;
            match_q  <= match_d;
        end
    end

    assign rdata  = rvalid_q ? (io_q ? io_rd_q : ram_rd_q) : rdata_q;
    assign rvalid = rvalid_q;
    assign leds   = leds_q;
    assign irq    = match_q;
endmodule
